// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Expand a requester index into its one-hot grant word.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] vec;
    vec = {{(N_REQ-1){1'b0}}, 1'b1} << id;
    return vec;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-to-4 priority encoder: the highest set bit wins, valid flags any set bit.
module prio_enc16
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  // Ascending scan so the last (highest) set bit overwrites earlier hits.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx   = req[i] ? ID_W'(i) : idx;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with a bounded hold time and a one-cycle gap between owners.
module rr_arb16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic [ID_W-1:0]  GNT_ID,
  output logic             BUSY
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [ID_W-1:0]   gnt_id_r;
  logic              busy_r;
  logic [ID_W-1:0]   last_r;
  logic [HOLD_W-1:0] hold_r;

  logic [N_REQ-1:0]  rot_s;
  logic [ID_W-1:0]   enc_idx_s;
  logic              enc_valid_s;
  logic [ID_W-1:0]   win_s;
  logic              release_s;

  // Rotate right by LAST so bit 15 holds REQ[LAST-1]: MSB-first search then starts one below LAST.
  always_comb begin
    rot_s = (REQ >> last_r) | (REQ << (5'd16 - {1'b0, last_r}));
  end

  prio_enc16 u_prio_enc16 (
    .req   (rot_s),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  // Undo the rotation (modulo 16) and decide whether the current owner lets go this edge.
  always_comb begin
    win_s     = enc_idx_s + last_r;
    release_s = DONE | ~REQ[gnt_id_r] | (hold_r == HOLD_LAST);
  end

  // Arbitration FSM with registered grant outputs; DONE only matters while a grant is active.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      gnt_r    <= 16'h0000;
      gnt_id_r <= 4'd0;
      busy_r   <= 1'b0;
      last_r   <= 4'd0;
      hold_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enc_valid_s) begin
            state_r  <= GRANT;
            gnt_r    <= id_to_onehot(win_s);
            gnt_id_r <= win_s;
            busy_r   <= 1'b1;
            last_r   <= win_s;
            hold_r   <= '0;
          end else begin
            state_r  <= IDLE;
            gnt_r    <= 16'h0000;
            gnt_id_r <= 4'd0;
            busy_r   <= 1'b0;
            hold_r   <= '0;
          end
        end
        GRANT: begin
          if (release_s) begin
            state_r  <= IDLE;
            gnt_r    <= 16'h0000;
            gnt_id_r <= 4'd0;
            busy_r   <= 1'b0;
            hold_r   <= '0;
          end else begin
            hold_r   <= hold_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          gnt_r    <= 16'h0000;
          gnt_id_r <= 4'd0;
          busy_r   <= 1'b0;
          hold_r   <= '0;
        end
      endcase
    end
  end

  assign GNT    = gnt_r;
  assign GNT_ID = gnt_id_r;
  assign BUSY   = busy_r;

endmodule

// File: tb/tb_rr_arb16.sv
// Directed and model-checked random stimulus for rr_arb16 built with MAX_HOLD=4.
module tb_rr_arb16;

  localparam int MAXH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] REQ = 16'h0000;
  logic        DONE = 1'b0;
  logic [15:0] GNT;
  logic [3:0]  GNT_ID;
  logic        BUSY;

  int n_pass  = 0;
  int n_total = 0;

  // model state for the random phase
  logic       m_busy;
  logic [3:0] m_id;
  logic [3:0] m_last;
  int         m_cnt;

  rr_arb16 #(.MAX_HOLD(MAXH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .DONE   (DONE),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all three outputs against an expected owner (or idle).
  task automatic check_out(input string tag, input logic busy, input logic [3:0] id);
    logic [15:0] one;
    one = 16'h0001;
    check({tag, ".gnt"}, GNT, busy ? (one << id) : 16'h0000);
    check({tag, ".id"}, {12'h000, GNT_ID}, busy ? {12'h000, id} : 16'h0000);
    check({tag, ".busy"}, {15'h0000, BUSY}, {15'h0000, busy});
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 16'h0000; DONE = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // reset state
    RST = 1'b1;
    tick();
    tick();
    check_out("reset", 1'b0, 4'd0);
    RST = 1'b0;

    // idle with no requests, DONE ignored
    DONE = 1'b1;
    tick();
    check_out("idle_done", 1'b0, 4'd0);
    DONE = 1'b0;

    // 8001 alternation: 15, gap, 0, gap, 15
    REQ = 16'h8001;
    tick(); check_out("alt_g15", 1'b1, 4'd15);
    DONE = 1'b1; tick(); check_out("alt_gap1", 1'b0, 4'd0);
    DONE = 1'b0; tick(); check_out("alt_g0", 1'b1, 4'd0);
    DONE = 1'b1; tick(); check_out("alt_gap2", 1'b0, 4'd0);
    DONE = 1'b0; tick(); check_out("alt_g15b", 1'b1, 4'd15);

    // full rotation under FFFF
    do_reset();
    REQ = 16'hFFFF;
    for (int k = 15; k >= 0; k--) begin
      tick(); check_out("rr_grant", 1'b1, 4'(k));
      DONE = 1'b1;
      tick(); check_out("rr_gap", 1'b0, 4'd0);
      DONE = 1'b0;
    end
    tick(); check_out("rr_wrap", 1'b1, 4'd15);

    // other requests changing mid-grant do not disturb the owner
    REQ = 16'h8000;
    tick(); check_out("mid_change1", 1'b1, 4'd15);
    REQ = 16'hC3FF;
    tick(); check_out("mid_change2", 1'b1, 4'd15);

    // hold expiry with MAX_HOLD=4; DONE high while idle must not block the grant
    do_reset();
    REQ = 16'h0010; DONE = 1'b1;
    tick(); check_out("hold_g", 1'b1, 4'd4);
    DONE = 1'b0;
    do_reset();
    REQ = 16'h0010;
    tick(); check_out("hold_c0", 1'b1, 4'd4);
    tick(); check_out("hold_c1", 1'b1, 4'd4);
    tick(); check_out("hold_c2", 1'b1, 4'd4);
    tick(); check_out("hold_c3", 1'b1, 4'd4);
    tick(); check_out("hold_gap", 1'b0, 4'd0);
    tick(); check_out("hold_regrant", 1'b1, 4'd4);
    // DONE coincident with expiry: single release
    tick(); tick(); tick();
    check_out("hold_last", 1'b1, 4'd4);
    DONE = 1'b1;
    tick(); check_out("exp_done_gap", 1'b0, 4'd0);
    DONE = 1'b0;
    tick(); check_out("exp_done_regrant", 1'b1, 4'd4);

    // owner 7 drops its request while 3 waits
    do_reset();
    REQ = 16'h0088;
    tick(); check_out("drop_g7", 1'b1, 4'd7);
    REQ = 16'h0008;
    tick(); check_out("drop_gap", 1'b0, 4'd0);
    tick(); check_out("drop_g3", 1'b1, 4'd3);

    // reset mid-grant of 9, then LAST restarts at 0 so 9 wins again
    do_reset();
    REQ = 16'h0201;
    tick(); check_out("rst_g9", 1'b1, 4'd9);
    RST = 1'b1;
    tick(); check_out("rst_drop", 1'b0, 4'd0);
    RST = 1'b0;
    tick(); check_out("rst_g9b", 1'b1, 4'd9);

    // random phase against an independent behavioural model
    do_reset();
    m_busy = 1'b0; m_id = 4'd0; m_last = 4'd0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) REQ = 16'($urandom);
      if ($urandom_range(0, 7) == 0) REQ = 16'h0000;
      DONE = ($urandom_range(0, 5) == 0);
      if (!m_busy) begin
        if (REQ != 16'h0000) begin
          for (int k = 1; k <= 16; k++) begin
            logic [3:0] cand;
            cand = m_last - 4'(k);
            if (!m_busy && REQ[cand]) begin
              m_busy = 1'b1; m_id = cand; m_last = cand; m_cnt = 0;
            end
          end
        end
      end else if (DONE || !REQ[m_id] || m_cnt == MAXH - 1) begin
        m_busy = 1'b0; m_id = 4'd0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      tick();
      check_out("rand", m_busy, m_id);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
